counter_ud_mc: RTL
==================

COUNTER_UD_MC -- requirements
Module: counter_ud_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter bit width (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent counters (>=1); SELW = max(1, $clog2(CHANNELS)).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  CHANNELS  per-channel count enable.
REQ-006 SHALL have port down  input  CHANNELS  per-channel direction: 1 = decrement, 0 = increment.
REQ-007 SHALL have port clr  input  CHANNELS  per-channel synchronous clear.
REQ-008 SHALL have port load_en  input  1  load strobe for channel ch_sel.
REQ-009 SHALL have port ch_sel  input  SELW  channel index targeted by load_en.
REQ-010 SHALL have port load_val  input  WIDTH  value loaded into the selected channel.
REQ-011 SHALL have port max_val  input  WIDTH  shared upper limit; each channel counts over 0..max_val.
REQ-012 SHALL have port sat_mode  input  1  1 = saturate at limits, 0 = wrap.
REQ-013 SHALL have port count  output  CHANNELS*WIDTH  registered counts; channel i at bits [i*WIDTH +: WIDTH].
REQ-014 SHALL have port tc  output  CHANNELS  registered one-cycle terminal-count pulse per channel.
REQ-015 SHALL have port zero  output  CHANNELS  combinational flag, channel count == 0.

Function
REQ-016 Each channel SHALL update independently each cycle with priority clr > load > count > hold.
REQ-017 clr[i]=1 SHALL set count[i] to 0 next cycle, with no tc.
REQ-018 load_en=1 with ch_sel==i and clr[i]=0 SHALL set count[i] to min(load_val, max_val) next cycle, with no tc.
REQ-019 load_en with ch_sel >= CHANNELS SHALL be ignored; no channel changes.
REQ-020 en[i]=1, down[i]=0, count[i] < max_val SHALL increment count[i] by 1.
REQ-021 en[i]=1, down[i]=0, count[i] >= max_val SHALL be an up-boundary: wrap mode gives 0, saturate mode gives max_val.
REQ-022 en[i]=1, down[i]=1, count[i] > 0 SHALL decrement count[i] by 1.
REQ-023 en[i]=1, down[i]=1, count[i] == 0 SHALL be a down-boundary: wrap mode gives max_val, saturate mode holds 0.
REQ-024 tc[i] SHALL be 1 in the cycle after any up- or down-boundary event in either mode, else 0; sustained enable at saturation SHALL give tc high every cycle.
REQ-025 Load or clear in the same cycle as a boundary condition SHALL take priority and suppress tc.
REQ-026 max_val changing below a channel's current count SHALL NOT alter that count until the next enabled step, which follows REQ-021/REQ-023.
REQ-027 max_val=0 SHALL give every enabled step a boundary event with count remaining 0.
REQ-028 All arithmetic SHALL be modulo 2^WIDTH-free: no step SHALL produce a value outside 0..max(max_val, current count).
REQ-029 sat_mode SHALL be sampled per cycle; changing it affects only subsequent steps.

Reset
REQ-030 rstn=0 SHALL asynchronously force all counts to 0 and tc to 0; zero then reads all ones.
REQ-031 Reset assertion mid-operation SHALL abandon any pending load or step; the first rising edge after deassertion SHALL apply normal rules to the inputs present at that edge.

Verification (WIDTH=4, CHANNELS=2 unless noted)
REQ-032 Wrap up: max_val=9, sat_mode=0, ch0 en up from 0 for 10 cycles -> count 1..9 then 0; tc[0] pulses once, the cycle after 9->0; ch1 untouched.
REQ-033 Saturate down: ch1 loaded 2, sat_mode=1, en down for 4 cycles -> 1, 0, 0, 0; tc[1] high on the 3rd and 4th result cycles.
REQ-034 Load clamp/priority: max_val=5, load_en, ch_sel=0, load_val=12 -> count0=5; same cycle with clr[0]=1 -> count0=0, tc=0.
REQ-035 Invalid select: CHANNELS=3 (SELW=2), load_en with ch_sel=3 -> all counts unchanged.
REQ-036 max_val shrink: count0=8, max_val changes 15->4, en up -> wrap mode gives 0 with tc, saturate mode gives 4 with tc.
REQ-037 Reset mid-run: rstn low between edges while counting -> count and tc go to 0 immediately, and the first edge after release counts from 0.

Source files
------------

// File: rtl/counter_ud_mc.sv
// counter_ud_mc
//   A bank of CHANNELS independent up/down counters that share one upper
//   limit (max_val) and one wrap/saturate mode. Each channel counts over
//   0..max_val. Per cycle, each channel applies the first matching rule:
//   clear, then load, then count, then hold. tc flags a boundary event.
//
// Parameters
//   WIDTH    : counter bit width (>= 2)
//   CHANNELS : number of independent counters (>= 1)
//   SELW     : width of ch_sel, max(1, $clog2(CHANNELS))
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   rstn     : asynchronous active-low reset
//   en       : per-channel count enable
//   down     : per-channel direction, 1 = decrement, 0 = increment
//   clr      : per-channel synchronous clear (highest priority)
//   load_en  : load strobe for channel ch_sel
//   ch_sel   : channel targeted by load_en; out-of-range values are ignored
//   load_val : value loaded, clamped to max_val
//   max_val  : shared upper limit
//   sat_mode : 1 = saturate at the limits, 0 = wrap
//   count    : registered counts, channel i at [i*WIDTH +: WIDTH]
//   tc       : registered one-cycle terminal-count pulse per channel
//   zero     : combinational flag, channel count == 0

module counter_ud_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS-1:0]       clr,
  input  logic                      load_en,
  input  logic [SELW-1:0]           ch_sel,
  input  logic [WIDTH-1:0]          load_val,
  input  logic [WIDTH-1:0]          max_val,
  input  logic                      sat_mode,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       zero
);

  logic [CHANNELS-1:0][WIDTH-1:0] count_q;
  logic [CHANNELS-1:0][WIDTH-1:0] count_d;
  logic [CHANNELS-1:0]            tc_q;
  logic [CHANNELS-1:0]            tc_d;
  logic [WIDTH-1:0]               load_clamped;

  // A loaded value never lands above the shared limit.
  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    count_d = count_q;
    tc_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr[i]) begin
        count_d[i] = '0;
      end else if (load_en && (32'(ch_sel) == i)) begin
        // An out-of-range ch_sel matches no channel, so it is ignored.
        count_d[i] = load_clamped;
      end else if (en[i]) begin
        if (!down[i]) begin
          // ">=" also catches a count left above a shrunken max_val.
          if (count_q[i] >= max_val) begin
            tc_d[i]    = 1'b1;
            count_d[i] = sat_mode ? max_val : '0;
          end else begin
            count_d[i] = count_q[i] + WIDTH'(1);
          end
        end else begin
          if (count_q[i] == '0) begin
            tc_d[i]    = 1'b1;
            count_d[i] = sat_mode ? '0 : max_val;
          end else begin
            count_d[i] = count_q[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      tc_q    <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    zero = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      zero[i] = (count_q[i] == '0);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule
